// File: rtl/fuzzy_pkg.sv
// Shared definitions for the flood-risk estimator and its sensor front end.
package fuzzy_pkg;

    // Upper bound of the fuzzy membership input range.
    localparam int MEMB_MAX = 100;

    typedef enum logic [1:0] {
        RAIN   = 2'd0,
        SOIL   = 2'd1,
        UPDATE = 2'd2
    } fe_state_t;

    // Unsigned clip of a byte to an upper limit.
    function automatic logic [7:0] clip_u8(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/sensor_avg_chan.sv
// One averaging channel: accumulates bytes, supports undoing a byte,
// and presents the floor-average clipped to CLIP_MAX.
module sensor_avg_chan
    import fuzzy_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int CLIP_MAX = MEMB_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] add_byte,
    input  logic       sub_en,
    input  logic [7:0] sub_byte,
    output logic [7:0] avg
);
    localparam int ACC_W = 8 + AVG_LOG2;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] add_v;
    logic [ACC_W-1:0] sub_v;
    logic [7:0]       avg_raw;

    assign add_v = add_en ? ACC_W'(add_byte) : '0;
    assign sub_v = sub_en ? ACC_W'(sub_byte) : '0;

    // Accumulate; a subtracted byte was always added earlier, so no underflow.
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else
            acc <= acc - sub_v + add_v;
    end

    // Window sum never exceeds 255 * 2^AVG_LOG2, so the shifted value fits a byte.
    assign avg_raw = 8'(acc >> AVG_LOG2);
    assign avg     = clip_u8(avg_raw, 8'(CLIP_MAX));

endmodule

// File: rtl/sensor_frontend.sv
// Deframes rain/soil byte pairs, averages 2^AVG_LOG2 frames, and drives the
// estimator inputs; drops the enable when the stream stalls.
module sensor_frontend
    import fuzzy_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int CLIP_MAX = MEMB_MAX,
    parameter int TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_sof,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] raw,
    output logic [7:0] sow,
    output logic       ef,
    output logic       frame_err
);
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam int FW = AVG_LOG2 + 1;
    localparam logic [FW-1:0] LAST_FRAME = FW'((1 << AVG_LOG2) - 1);

    fe_state_t     state, nxt;
    logic [SW-1:0] stale_cnt;
    logic [FW-1:0] frame_cnt;
    logic [7:0]    rain_hold;
    logic [7:0]    rain_avg, soil_avg;

    logic flush, take, rain_take, resync, frame_done, bad_byte, win_clr;

    // Timeout flush outranks byte acceptance on the same edge.
    assign flush   = (stale_cnt == SW'(TIMEOUT - 1));
    assign win_clr = flush || (state == UPDATE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= RAIN;
        else     state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        case (state)
            RAIN:    if (rain_take) nxt = SOIL;
            SOIL:    if (frame_done) nxt = (frame_cnt == LAST_FRAME) ? UPDATE : RAIN;
            UPDATE:  nxt = RAIN;
            default: nxt = RAIN;
        endcase
        if (flush) nxt = RAIN;
    end

    // Handshake and per-byte decode.
    always_comb begin
        in_ready   = (state != UPDATE);
        take       = in_valid && in_ready && !flush;
        rain_take  = take && in_sof;
        resync     = take && in_sof && (state == SOIL);
        frame_done = take && !in_sof && (state == SOIL);
        bad_byte   = take && !in_sof && (state == RAIN);
    end

    // Stale counter: cleared per completed frame, saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst || frame_done)              stale_cnt <= '0;
        else if (stale_cnt != SW'(TIMEOUT)) stale_cnt <= stale_cnt + SW'(1);
    end

    // Frame count within the current window.
    always_ff @(posedge clk) begin
        if (rst || win_clr)  frame_cnt <= '0;
        else if (frame_done) frame_cnt <= frame_cnt + FW'(1);
    end

    // Rain byte of the open frame, kept so a resync can back it out.
    always_ff @(posedge clk) begin
        if (rst)            rain_hold <= '0;
        else if (rain_take) rain_hold <= in_data;
    end

    // Estimator outputs; raw/sow only move in UPDATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw       <= '0;
            sow       <= '0;
            ef        <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state == UPDATE) begin
                raw <= rain_avg;
                sow <= soil_avg;
                ef  <= 1'b1;
            end else if (flush) begin
                ef  <= 1'b0;
            end
            if (bad_byte || resync) frame_err <= 1'b1;
        end
    end

    sensor_avg_chan #(.AVG_LOG2(AVG_LOG2), .CLIP_MAX(CLIP_MAX)) u_rain (
        .clk      (clk),
        .rst      (rst),
        .clr      (win_clr),
        .add_en   (rain_take),
        .add_byte (in_data),
        .sub_en   (resync),
        .sub_byte (rain_hold),
        .avg      (rain_avg)
    );

    sensor_avg_chan #(.AVG_LOG2(AVG_LOG2), .CLIP_MAX(CLIP_MAX)) u_soil (
        .clk      (clk),
        .rst      (rst),
        .clr      (win_clr),
        .add_en   (frame_done),
        .add_byte (in_data),
        .sub_en   (1'b0),
        .sub_byte (8'd0),
        .avg      (soil_avg)
    );

endmodule

// File: tb/tb_sensor_frontend.sv
// Directed + randomized bench for sensor_frontend against a frame-queue model.
module tb_sensor_frontend;
    localparam int L    = 2;
    localparam int NWIN = 1 << L;
    localparam int CMAX = 100;
    localparam int T    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_sof = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] raw, sow;
    logic       ef, frame_err;

    int n_vec = 0;
    int n_err = 0;

    sensor_frontend #(.AVG_LOG2(L), .CLIP_MAX(CMAX), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sof(in_sof),
        .in_valid(in_valid), .in_ready(in_ready), .raw(raw), .sow(sow),
        .ef(ef), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Reference model: completed frames of the open window, open rain byte,
    // cycles since last completed frame, and a pending-update flag.
    int   q_rain[$];
    int   q_soil[$];
    bit   m_have;
    int   m_idle;
    bit   m_busy;
    int   m_raw, m_sow;
    bit   m_ef, m_err;

    task automatic chk(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int win_avg(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        s = s / NWIN;
        return (s > CMAX) ? CMAX : s;
    endfunction

    task automatic m_step(input bit r, input bit v, input bit s, input int d);
        bit fl;
        if (r) begin
            q_rain.delete(); q_soil.delete();
            m_have = 0; m_idle = 0; m_busy = 0;
            m_raw = 0; m_sow = 0; m_ef = 0; m_err = 0;
            return;
        end
        if (m_busy) begin
            m_raw = win_avg(q_rain);
            m_sow = win_avg(q_soil);
            m_ef  = 1;
            q_rain.delete(); q_soil.delete();
            m_busy = 0;
            if (m_idle < T) m_idle++;
            return;
        end
        fl = (m_idle == T - 1);
        if (m_idle < T) m_idle++;
        if (fl) begin
            m_ef = 0;
            q_rain.delete(); q_soil.delete();
            m_have = 0;
            return;
        end
        if (!v) return;
        if (s) begin
            if (m_have) begin
                m_err = 1;
                void'(q_rain.pop_back());
            end
            m_have = 1;
            q_rain.push_back(d);
        end else if (!m_have) begin
            m_err = 1;
        end else begin
            q_soil.push_back(d);
            m_have = 0;
            m_idle = 0;
            if (q_soil.size() == NWIN) m_busy = 1;
        end
    endtask

    // One clock: drive, check handshake, advance model, check outputs after edge.
    task automatic tick(input bit r, input bit v, input bit s, input int d, output bit acc);
        rst = r; in_valid = v; in_sof = s; in_data = 8'(d);
        if (!r) chk("in_ready", int'(in_ready), int'(!m_busy));
        acc = v && !m_busy && !r;
        m_step(r, v, s, d);
        @(posedge clk);
        #1;
        chk("raw", int'(raw), m_raw);
        chk("sow", int'(sow), m_sow);
        chk("ef", int'(ef), int'(m_ef));
        chk("frame_err", int'(frame_err), int'(m_err));
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, a);
    endtask

    task automatic send_byte(input bit s, input int d);
        bit a;
        a = 0;
        for (int k = 0; k < 4 && !a; k++) tick(0, 1, s, d, a);
        if (!a) begin
            n_vec++; n_err++;
            $error("FAIL send_byte: observed not-accepted expected accepted");
        end
    endtask

    task automatic frame(input int r, input int s);
        send_byte(1, r);
        send_byte(0, s);
    endtask

    initial begin
        bit a;
        bit ph;
        bit s;
        m_step(1, 0, 0, 0);
        tick(1, 0, 0, 0, a);
        tick(1, 0, 0, 0, a);
        chk("reset_raw", int'(raw), 0);
        chk("reset_ef", int'(ef), 0);

        // Basic window and one-cycle UPDATE bubble.
        frame(10, 80); frame(20, 80); frame(30, 84); frame(40, 88);
        idle(2);
        chk("t1_raw", int'(raw), 25);
        chk("t1_sow", int'(sow), 83);
        chk("t1_ef", int'(ef), 1);

        // Clipping.
        for (int i = 0; i < 4; i++) frame(200, 255);
        idle(2);
        chk("t2_raw", int'(raw), 100);
        chk("t2_sow", int'(sow), 100);

        // Stray soil byte, then resync inside a window.
        send_byte(0, 8'h33);
        chk("t3_err", int'(frame_err), 1);
        frame(4, 8); frame(4, 8); frame(4, 8);
        send_byte(1, 99);
        frame(8, 12);
        idle(2);
        chk("t3_raw", int'(raw), 5);
        chk("t3_sow", int'(sow), 9);

        // Timeout: ef falls, data holds; partial window discarded.
        idle(T);
        chk("t4_ef", int'(ef), 0);
        chk("t4_raw", int'(raw), 5);
        frame(90, 90); frame(90, 90);
        idle(T + 2);
        for (int i = 0; i < 4; i++) frame(50, 60);
        idle(2);
        chk("t4_raw2", int'(raw), 50);
        chk("t4_sow2", int'(sow), 60);

        // Reset mid-window.
        frame(7, 7); frame(7, 7); send_byte(1, 7);
        m_step(1, 0, 0, 0);
        tick(1, 0, 0, 0, a);
        chk("t5_raw", int'(raw), 0);
        for (int i = 0; i < 4; i++) frame(60, 60);
        idle(2);
        chk("t5_raw2", int'(raw), 60);
        chk("t5_sow2", int'(sow), 60);

        // Valid held across UPDATE with random sof.
        frame(1, 2); frame(1, 2); frame(1, 2);
        send_byte(1, 1);
        tick(0, 1, 0, 2, a);
        for (int i = 0; i < 3; i++) tick(0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 255), a);
        idle(T + 2);

        // Randomized traffic with occasional stalls past the timeout.
        ph = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                idle($urandom_range(T, T + 6));
            end else begin
                s = (ph == 0);
                if ($urandom_range(0, 9) == 0) s = !s;
                tick(0, 1'($urandom_range(0, 3) != 0), s, $urandom_range(0, 255), a);
                if (a) ph = s;
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
